axi_sram_slave: RTL and testbench

- AXI3 slave (responder) that terminates the 32-bit AXI master port exported by the core's To_AXI bridge.
- Translates read and write bursts into accesses on a single-port synchronous word SRAM.
- Serves as the memory model for core-level simulation and as the on-chip RAM in SoC integration.
- Handles one transaction at a time, with fair read/write arbitration.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_burst_addr.sv | 51 +++++
 rtl/axi_sram_slave.sv | 211 +++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared constants for the AXI SRAM slave: response codes, burst types and
// the slave FSM state encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_REQ  = 3'd1;
  localparam state_t ST_RD_DATA = 3'd2;
  localparam state_t ST_WR_DATA = 3'd3;
  localparam state_t ST_WR_RESP = 3'd4;

endpackage

// File: rtl/axi_burst_addr.sv
// Burst word-address generator.
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   load_i   load start address and burst type (address handshake)
//   addr_i   start word address
//   burst_i  burst type
//   adv_i    step to the next beat address
//   addr_o   current word address
// FIXED holds the address; every other burst type steps by one word and
// wraps modulo 2^ADDR_W.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        burst_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        burst_q, burst_d;

  always_comb begin
    addr_d  = addr_q;
    burst_d = burst_q;
    if (load_i) begin
      addr_d  = addr_i;
      burst_d = burst_i;
    end else if (adv_i && (burst_q != BURST_FIXED)) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      burst_q <= BURST_FIXED;
    end else begin
      addr_q  <= addr_d;
      burst_q <= burst_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave terminating a 32-bit master onto a single-port synchronous
// word SRAM. One transaction at a time; reads and writes alternate under
// contention.
//   aclk/areset          clock, synchronous active-high reset
//   ar*/r*               read address and read data channels
//   aw*/w*/b*            write address, write data and response channels
//   ram_en/ram_we        SRAM enable and byte write enables
//   ram_addr/ram_wdata   SRAM word address and write data
//   ram_rdata            SRAM read data (valid the cycle after a read enable)
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | arbitrate AR/AW, accept one address
// RD_REQ     | issue SRAM read for the current beat
// RD_DATA    | present read beat, hold until rready
// WR_DATA    | accept write beats, one SRAM write per beat
// WR_RESP    | present write response, hold until bready
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int ID_W   = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t          state_q, state_d;
  logic            prio_wr_q, prio_wr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      beat_q, beat_d;
  logic            err_q, err_d;

  logic sel_rd, sel_wr, in_idle;
  logic ar_hs, aw_hs, rd_hs, wr_beat;
  logic last_beat;
  logic addr_load, addr_adv;
  logic [ADDR_W-1:0] addr_start, addr_cur;
  logic [1:0]        burst_start;

  // Size, write-data ID and the byte-offset/alias address bits carry no
  // meaning for a fixed 32-bit word memory.
  logic unused_inputs;
  assign unused_inputs = ^{arsize, awsize, wid,
                           araddr[31:ADDR_W+2], araddr[1:0],
                           awaddr[31:ADDR_W+2], awaddr[1:0]};

  // Under contention the priority flag picks the winner; a lone valid wins.
  assign sel_rd  = arvalid && (!awvalid || !prio_wr_q);
  assign sel_wr  = awvalid && (!arvalid ||  prio_wr_q);
  assign in_idle = (state_q == ST_IDLE) && !areset;

  assign arready = in_idle && sel_rd;
  assign awready = in_idle && sel_wr;
  assign ar_hs   = arready;
  assign aw_hs   = awready;

  assign last_beat = (beat_q == len_q);

  assign rvalid  = (state_q == ST_RD_DATA) && !areset;
  assign rd_hs   = rvalid && rready;
  assign rdata   = ram_rdata;
  assign rid     = id_q;
  assign rresp   = RESP_OKAY;
  assign rlast   = rvalid && last_beat;

  assign wready  = (state_q == ST_WR_DATA) && !areset;
  assign wr_beat = wready && wvalid;

  assign bvalid  = (state_q == ST_WR_RESP) && !areset;
  assign bid     = id_q;
  assign bresp   = err_q ? RESP_SLVERR : RESP_OKAY;

  assign ram_en    = !areset && ((state_q == ST_RD_REQ) || wr_beat);
  assign ram_we    = wr_beat ? wstrb : 4'b0000;
  assign ram_addr  = addr_cur;
  assign ram_wdata = wdata;

  assign addr_load   = ar_hs || aw_hs;
  assign addr_start  = ar_hs ? araddr[ADDR_W+1:2] : awaddr[ADDR_W+1:2];
  assign burst_start = ar_hs ? arburst : awburst;
  // Stepping past the final write beat is harmless: the next burst reloads.
  assign addr_adv    = (rd_hs && !last_beat) || wr_beat;

  axi_burst_addr #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk_i   (aclk),
    .rst_i   (areset),
    .load_i  (addr_load),
    .addr_i  (addr_start),
    .burst_i (burst_start),
    .adv_i   (addr_adv),
    .addr_o  (addr_cur)
  );

  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    id_d      = id_q;
    len_d     = len_q;
    beat_d    = beat_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          id_d      = arid;
          len_d     = arlen;
          beat_d    = 8'd0;
          prio_wr_d = ~prio_wr_q;
          state_d   = ST_RD_REQ;
        end else if (aw_hs) begin
          id_d      = awid;
          len_d     = awlen;
          beat_d    = 8'd0;
          err_d     = 1'b0;
          prio_wr_d = ~prio_wr_q;
          state_d   = ST_WR_DATA;
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (rready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_WR_DATA: begin
        if (wvalid) begin
          // Burst length comes from awlen; wlast only flags an error.
          if (wlast != last_beat) begin
            err_d = 1'b1;
          end
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            state_d = ST_WR_RESP;
          end
        end
      end
      ST_WR_RESP: begin
        if (bready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      prio_wr_q <= 1'b0;
      id_q      <= '0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int ADDR_W = 14;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              aclk = 1'b0;
  logic              areset;
  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [ID_W-1:0]   wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  always #5 aclk = ~aclk;

  axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // SRAM environment model, with a side port for preloading.
  logic [31:0]       sram [0:DEPTH-1] = '{default: '0};
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0]       pl_data = '0;

  always @(posedge aclk) begin
    if (pl_en) begin
      sram[pl_addr] <= pl_data;
    end else if (ram_en) begin
      if (ram_we == 4'b0000) ram_rdata <= sram[ram_addr];
      else for (int k = 0; k < 4; k++)
        if (ram_we[k]) sram[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  // Reference memory: expected contents per the AXI/SRAM rules.
  logic [31:0] ref_mem [0:DEPTH-1] = '{default: '0};
  logic [31:0] wbuf    [0:255];
  logic [31:0] exp_buf [0:255];

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] d0;
    logic [31:0] dstep;
    int          bad_beat;
    logic [1:0]  exp_resp;
    logic [31:0] exp0;
    logic [31:0] estep;
    int          hold;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = ADDR_W'(w); pl_data = d;
    @(posedge aclk);
    @(negedge aclk);
    pl_en = 1'b0;
    ref_mem[w] = d;
  endtask

  task automatic ref_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [3:0] strb);
    int w;
    w = int'((addr >> 2) % DEPTH);
    for (int b = 0; b <= len; b++) begin
      for (int k = 0; k < 4; k++)
        if (strb[k]) ref_mem[w][8*k +: 8] = wbuf[b][8*k +: 8];
      if (burst != BURST_FIXED) w = (w + 1) % DEPTH;
    end
  endtask

  task automatic ref_read_exp(input logic [31:0] addr, input int len, input logic [1:0] burst);
    int w;
    w = int'((addr >> 2) % DEPTH);
    for (int b = 0; b <= len; b++) begin
      exp_buf[b] = ref_mem[w];
      if (burst != BURST_FIXED) w = (w + 1) % DEPTH;
    end
  endtask

  task automatic ar_handshake(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [2:0] size);
    int cnt;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    #1;
    cnt = 0;
    while (!arready && cnt < 100) begin tick(); #1; cnt++; end
    if (!arready) begin
      check("arready_timeout", 32'(arready), 32'd1);
      arvalid = 1'b0;
      return;
    end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic aw_handshake(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [2:0] size);
    int cnt;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    #1;
    cnt = 0;
    while (!awready && cnt < 100) begin tick(); #1; cnt++; end
    if (!awready) begin
      check("awready_timeout", 32'(awready), 32'd1);
      awvalid = 1'b0;
      return;
    end
    tick();
    awvalid = 1'b0;
  endtask

  task automatic read_data(input logic [3:0] id, input int len, input int hold);
    int cnt;
    for (int b = 0; b <= len; b++) begin
      #1;
      cnt = 0;
      while (!rvalid && cnt < 100) begin tick(); #1; cnt++; end
      if (!rvalid) begin
        check("rvalid_timeout", 32'(rvalid), 32'd1);
        return;
      end
      check("rdata", rdata, exp_buf[b]);
      check("rid", 32'(rid), 32'(id));
      check("rresp", 32'(rresp), 32'(RESP_OKAY));
      check("rlast", 32'(rlast), 32'(b == len));
      for (int h = 0; h < hold; h++) begin
        tick(); #1;
        check("rvalid_hold", 32'(rvalid), 32'd1);
        check("rdata_hold", rdata, exp_buf[b]);
        check("rlast_hold", 32'(rlast), 32'(b == len));
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  task automatic write_data(input logic [3:0] id, input int len, input logic [3:0] strb,
                            input int bad_beat, input bit gaps, input logic [1:0] exp_resp);
    int cnt;
    for (int b = 0; b <= len; b++) begin
      if (gaps) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb;
      wlast = (b == len) ^ (b == bad_beat);
      #1;
      cnt = 0;
      while (!wready && cnt < 100) begin tick(); #1; cnt++; end
      if (!wready) begin
        check("wready_timeout", 32'(wready), 32'd1);
        wvalid = 1'b0; wlast = 1'b0;
        return;
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    cnt = 0;
    while (!bvalid && cnt < 100) begin tick(); #1; cnt++; end
    if (!bvalid) begin
      check("bvalid_timeout", 32'(bvalid), 32'd1);
      return;
    end
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    #1;
    check("bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input int hold);
    ar_handshake(id, addr, len, burst, size);
    #1;
    check("rd_lat_early", 32'(rvalid), 32'd0);
    tick(); #1;
    check("rd_lat", 32'(rvalid), 32'd1);
    read_data(id, int'(len), hold);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                          input int bad_beat, input bit gaps, input logic [1:0] exp_resp);
    aw_handshake(id, addr, len, burst, size);
    write_data(id, int'(len), strb, bad_beat, gaps, exp_resp);
    ref_write(addr, int'(len), burst, strb);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_waddr;

    //        wr  id     addr           len   burst        strb   d0            dstep   bad  resp         exp0          estep  hold
    vecs[0]  = '{1'b0, 4'd3,  32'h0000_0040, 8'd0, BURST_INCR,  4'hF, 32'h0,        32'h0,  -1, RESP_OKAY,   32'hDEADBEEF, 32'h0,  0};
    vecs[1]  = '{1'b1, 4'd5,  32'h0000_0100, 8'd3, BURST_INCR,  4'hF, 32'h1,        32'h1,  -1, RESP_OKAY,   32'h0,        32'h0,  0};
    vecs[2]  = '{1'b0, 4'd6,  32'h0000_0100, 8'd3, BURST_INCR,  4'hF, 32'h0,        32'h0,  -1, RESP_OKAY,   32'h1,        32'h1,  1};
    vecs[3]  = '{1'b1, 4'd7,  32'h0000_0200, 8'd0, BURST_FIXED, 4'h5, 32'hAABBCCDD, 32'h0,  -1, RESP_OKAY,   32'h0,        32'h0,  0};
    vecs[4]  = '{1'b0, 4'd8,  32'h0000_0200, 8'd2, BURST_FIXED, 4'hF, 32'h0,        32'h0,  -1, RESP_OKAY,   32'h11BB33DD, 32'h0,  0};
    vecs[5]  = '{1'b1, 4'd9,  32'h0000_0300, 8'd1, BURST_INCR,  4'hF, 32'h55,       32'h1,   0, RESP_SLVERR, 32'h0,        32'h0,  0};
    vecs[6]  = '{1'b0, 4'd10, 32'h0000_0300, 8'd1, BURST_INCR,  4'hF, 32'h0,        32'h0,  -1, RESP_OKAY,   32'h55,       32'h1,  0};
    vecs[7]  = '{1'b0, 4'd11, 32'h0000_FFFC, 8'd1, BURST_INCR,  4'hF, 32'h0,        32'h0,  -1, RESP_OKAY,   32'hCAFE0001, 32'h1,  0};
    vecs[8]  = '{1'b0, 4'd12, 32'h0001_0040, 8'd0, BURST_INCR,  4'hF, 32'h0,        32'h0,  -1, RESP_OKAY,   32'hDEADBEEF, 32'h0,  0};
    vecs[9]  = '{1'b1, 4'd1,  32'h0000_0400, 8'd2, BURST_WRAP,  4'hF, 32'h700,      32'h11, -1, RESP_OKAY,   32'h0,        32'h0,  0};
    vecs[10] = '{1'b0, 4'd2,  32'h0000_0400, 8'd2, 2'b11,       4'hF, 32'h0,        32'h0,  -1, RESP_OKAY,   32'h700,      32'h11, 0};
    vecs[11] = '{1'b1, 4'd4,  32'h0000_0500, 8'd0, BURST_INCR,  4'hF, 32'h77,       32'h0,   0, RESP_SLVERR, 32'h0,        32'h0,  0};

    areset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = BURST_INCR; arvalid = 1'b0;
    rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = BURST_INCR; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    @(negedge aclk);
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h80, 32'h11223344);
    preload(DEPTH - 1, 32'hCAFE0001);
    preload(0, 32'hCAFE0002);
    #1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    tick();
    areset = 1'b0;

    // Contention from reset: R, then W, then R again.
    arid = 4'd3; araddr = 32'h40; arlen = 8'd0; arburst = BURST_INCR; arvalid = 1'b1;
    awid = 4'd4; awaddr = 32'h600; awlen = 8'd0; awburst = BURST_INCR; awvalid = 1'b1;
    #1;
    check("arb1_arready", 32'(arready), 32'd1);
    check("arb1_awready", 32'(awready), 32'd0);
    ar_handshake(4'd3, 32'h40, 8'd0, BURST_INCR, 3'd2);
    #1;
    check("arb_awready_busy", 32'(awready), 32'd0);
    tick();
    exp_buf[0] = 32'hDEADBEEF;
    read_data(4'd3, 0, 5);
    arid = 4'd5; araddr = 32'h600; arlen = 8'd0; arburst = BURST_INCR; arvalid = 1'b1;
    #1;
    check("arb2_awready", 32'(awready), 32'd1);
    check("arb2_arready", 32'(arready), 32'd0);
    aw_handshake(4'd4, 32'h600, 8'd0, BURST_INCR, 3'd2);
    wbuf[0] = 32'h12345678;
    write_data(4'd4, 0, 4'hF, -1, 1'b0, RESP_OKAY);
    ref_write(32'h600, 0, BURST_INCR, 4'hF);
    awid = 4'd6; awaddr = 32'h640; awlen = 8'd0; awburst = BURST_INCR; awvalid = 1'b1;
    #1;
    check("arb3_arready", 32'(arready), 32'd1);
    check("arb3_awready", 32'(awready), 32'd0);
    exp_buf[0] = 32'h12345678;
    do_read(4'd5, 32'h600, 8'd0, BURST_INCR, 3'd2, 0);
    wbuf[0] = 32'h9;
    do_write(4'd6, 32'h640, 8'd0, BURST_INCR, 3'd2, 4'hF, -1, 1'b0, RESP_OKAY);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        for (int b = 0; b <= int'(vecs[i].len); b++) wbuf[b] = vecs[i].d0 + 32'(b) * vecs[i].dstep;
        do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst, 3'd2, vecs[i].strb,
                 vecs[i].bad_beat, 1'b0, vecs[i].exp_resp);
      end else begin
        for (int b = 0; b <= int'(vecs[i].len); b++) exp_buf[b] = vecs[i].exp0 + 32'(b) * vecs[i].estep;
        do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst, 3'd2, vecs[i].hold);
      end
    end

    // Reset in the middle of a len-7 read.
    ref_read_exp(32'h100, 7, BURST_INCR);
    ar_handshake(4'hA, 32'h100, 8'd7, BURST_INCR, 3'd2);
    tick(); #1;
    check("mid_rvalid", 32'(rvalid), 32'd1);
    check("mid_rdata", rdata, exp_buf[0]);
    areset = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_ram_en", 32'(ram_en), 32'd0);
    tick();
    areset = 1'b0;
    #1;
    check("post_rst_rvalid", 32'(rvalid), 32'd0);
    check("post_rst_arready_lo", 32'(arready), 32'd0);
    arvalid = 1'b1;
    #1;
    check("post_rst_arready_hi", 32'(arready), 32'd1);
    ref_read_exp(32'h100, 3, BURST_INCR);
    do_read(4'hB, 32'h100, 8'd3, BURST_INCR, 3'd2, 0);

    // Randomized transactions against the reference memory.
    last_waddr = 32'h0;
    for (int t = 0; t < 40; t++) begin
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [2:0]  size;
      logic [3:0]  strb;
      int          bad;
      id    = 4'($urandom);
      addr  = $urandom;
      len   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      burst = 2'($urandom);
      size  = 3'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        strb = 4'($urandom);
        bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len))) : -1;
        for (int b = 0; b <= int'(len); b++) wbuf[b] = $urandom;
        do_write(id, addr, len, burst, size, strb, bad, (len <= 16),
                 (bad >= 0) ? RESP_SLVERR : RESP_OKAY);
        last_waddr = addr;
      end else begin
        if ($urandom_range(0, 1) == 1) addr = last_waddr;
        ref_read_exp(addr, int'(len), burst);
        do_read(id, addr, len, burst, size, (len <= 16) ? int'($urandom_range(0, 2)) : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
